// File: rtl/elevator_ctrl.sv
// Single-car collective-selective elevator controller: request latching,
// direction scheduling, floor stepping and door dwell in one block.
module elevator_ctrl #(
  parameter int N_FLOORS    = 10,
  parameter int FW          = $clog2(N_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] car_btn_n,
  input  logic [N_FLOORS-1:0] call_up_n,
  input  logic [N_FLOORS-1:0] call_dn_n,
  input  logic                door_hold,
  output logic [FW-1:0]       floor,
  output logic [N_FLOORS-1:0] floor_oh,
  output logic                door_open,
  output logic                moving_up,
  output logic                moving_dn,
  output logic                dir,
  output logic [N_FLOORS-1:0] req_car,
  output logic [N_FLOORS-1:0] req_up,
  output logic [N_FLOORS-1:0] req_dn
);

  localparam int MCW = $clog2(MOVE_CYCLES + 1);
  localparam int DCW = $clog2(DOOR_CYCLES + 1);
  localparam logic [MCW-1:0] MV_LOAD = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DR_LOAD = DCW'(DOOR_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] UP_MASK = ~(N_FLOORS'(1) << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] DN_MASK = ~N_FLOORS'(1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  state_t               state, state_d;
  logic [MCW-1:0]       mv_cnt, mv_cnt_d;
  logic [DCW-1:0]       dr_cnt, dr_cnt_d;
  logic                 dir_d;
  logic [FW-1:0]        floor_d, sf;
  logic [N_FLOORS-1:0]  floor_oh_d;
  logic [N_FLOORS-1:0]  pr_up, pr_dn, all_req;
  logic [N_FLOORS-1:0]  clr_car, clr_up, clr_dn;
  logic                 arrive, above, below, here_s;
  logic                 hall_dir_s, hall_opp_s, ahead_dir_s;
  logic                 serve_dir, stop, svc, step, door_press, clr_en;

  assign pr_up   = ~call_up_n & UP_MASK;
  assign pr_dn   = ~call_dn_n & DN_MASK;
  assign all_req = req_car | req_up | req_dn;

  // sf is the floor being judged: the arrival floor on a step, else the current one
  assign arrive = (state == MOVE_UP || state == MOVE_DN) && (mv_cnt == '0);
  always_comb begin
    sf = floor;
    if (arrive) sf = (state == MOVE_UP) ? floor + FW'(1) : floor - FW'(1);
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(sf)) above = above | all_req[i];
      if (i < int'(sf)) below = below | all_req[i];
    end
  end

  assign here_s      = req_car[sf] | req_up[sf] | req_dn[sf];
  assign hall_dir_s  = dir ? req_dn[sf] : req_up[sf];
  assign hall_opp_s  = dir ? req_up[sf] : req_dn[sf];
  assign ahead_dir_s = dir ? below : above;
  // Reverse only when the sole reason to stop here is an opposite-direction call
  assign serve_dir   = (ahead_dir_s | hall_dir_s | ~hall_opp_s) ? dir : ~dir;
  assign stop        = req_car[sf] | hall_dir_s | ~ahead_dir_s;
  assign door_press  = ~car_btn_n[floor] | (dir ? pr_dn[floor] : pr_up[floor]);

  always_comb begin
    state_d  = state;
    dir_d    = dir;
    mv_cnt_d = mv_cnt;
    dr_cnt_d = dr_cnt;
    svc      = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (here_s) begin
          svc = 1'b1; state_d = DOOR;
        end else if (!dir && above) begin
          state_d = MOVE_UP; mv_cnt_d = MV_LOAD;
        end else if (dir && below) begin
          state_d = MOVE_DN; mv_cnt_d = MV_LOAD;
        end else if (above) begin
          dir_d = 1'b0; state_d = MOVE_UP; mv_cnt_d = MV_LOAD;
        end else if (below) begin
          dir_d = 1'b1; state_d = MOVE_DN; mv_cnt_d = MV_LOAD;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (mv_cnt != '0) mv_cnt_d = mv_cnt - MCW'(1);
        else begin
          step = 1'b1;
          if (stop) begin
            svc = 1'b1; state_d = DOOR;
          end else mv_cnt_d = MV_LOAD;
        end
      end
      DOOR: begin
        if (door_hold || door_press) dr_cnt_d = DR_LOAD;
        else if (dr_cnt != '0)       dr_cnt_d = dr_cnt - DCW'(1);
        else                         state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (svc) begin
      dir_d    = serve_dir;
      dr_cnt_d = DR_LOAD;
    end
  end

  always_comb begin
    floor_d    = floor;
    floor_oh_d = floor_oh;
    if (step) begin
      floor_d    = sf;
      floor_oh_d = (state == MOVE_UP) ? floor_oh << 1 : floor_oh >> 1;
    end
  end

  // While the door is open the served bits stay cleared, so repeat presses are absorbed
  assign clr_en  = svc | (state == DOOR);
  assign clr_car = clr_en ? floor_oh_d : '0;
  assign clr_up  = (clr_en && !dir_d) ? floor_oh_d : '0;
  assign clr_dn  = (clr_en &&  dir_d) ? floor_oh_d : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor    <= '0;
      floor_oh <= N_FLOORS'(1);
      dir      <= 1'b0;
      mv_cnt   <= '0;
      dr_cnt   <= '0;
      req_car  <= '0;
      req_up   <= '0;
      req_dn   <= '0;
    end else begin
      state    <= state_d;
      floor    <= floor_d;
      floor_oh <= floor_oh_d;
      dir      <= dir_d;
      mv_cnt   <= mv_cnt_d;
      dr_cnt   <= dr_cnt_d;
      req_car  <= (req_car | ~car_btn_n) & ~clr_car;
      req_up   <= (req_up  | pr_up)      & ~clr_up;
      req_dn   <= (req_dn  | pr_dn)      & ~clr_dn;
    end
  end

  assign door_open = (state == DOOR);
  assign moving_up = (state == MOVE_UP);
  assign moving_dn = (state == MOVE_DN);

endmodule
